// File: rtl/multi_linebuffer.sv
// ---------------------------------------------------------------------------
// multi_linebuffer
//
// Keeps the previous NUM_LINES-1 video lines in a rotating ring of NUM_LINES
// single-port RAM banks. For every accepted pixel it emits a column-aligned
// vertical tap vector: the current pixel plus the same column from each of
// the older lines. It feeds 2-D window/filter stages such as a 3x3 kernel.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (release is synchronous)
//   cfg_line_len  pixels per line; sampled on the first clock after reset
//                 release and on an accepted start-of-frame pixel
//   data_in       input pixel
//   in_valid      pixel qualifier (no backpressure)
//   in_sof        start of frame, meaningful only with in_valid
//   data_out      tap vector; slice 0 is the current pixel, slice k is the
//                 pixel from k lines earlier in the same column
//   out_valid     tap vector qualifier
//   out_eol       marks the vector of the last column of a line
//   out_col       column index of the emitted vector
//
// Inputs sampled at a rising edge appear on the outputs right after that
// edge (one clock of latency from the cycle the pixel is presented).
// ---------------------------------------------------------------------------
module multi_linebuffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_LENGTH = 1920,
    parameter int NUM_LINES  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH:0]             cfg_line_len,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            in_valid,
    input  logic                            in_sof,
    output logic [NUM_LINES*DATA_WIDTH-1:0] data_out,
    output logic                            out_valid,
    output logic                            out_eol,
    output logic [ADDR_WIDTH-1:0]           out_col
);

    localparam int SEL_W = $clog2(NUM_LINES);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_LENGTH);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LINES - 1);

    // Line state
    logic [ADDR_WIDTH-1:0] col_reg;
    logic [SEL_W-1:0]      wr_sel_reg;
    logic [SEL_W-1:0]      filled_reg;
    logic [LEN_W-1:0]      len_reg;
    logic                  len_loaded_reg;

    // Output-side state
    logic [SEL_W-1:0]      tap_sel_reg;   // bank that held the current line
    logic [DATA_WIDTH-1:0] pix_reg;
    logic                  have_data_reg; // clears data_out after reset
    logic                  out_valid_reg;
    logic                  out_eol_reg;
    logic [ADDR_WIDTH-1:0] out_col_reg;

    logic [NUM_LINES-1:0][DATA_WIDTH-1:0] rd_bus;

    // Effective values for this cycle: an accepted sof restarts the frame
    // in place, so the sof pixel is treated as column 0 of line 0 with the
    // freshly sampled length.
    logic                  sof_accept;
    logic [LEN_W-1:0]      len_clamped;
    logic [LEN_W-1:0]      eff_len;
    logic [ADDR_WIDTH-1:0] eff_col;
    logic [SEL_W-1:0]      eff_sel;
    logic [SEL_W-1:0]      eff_filled;
    logic                  at_eol;
    logic [SEL_W-1:0]      sel_adv;
    logic [SEL_W-1:0]      filled_adv;

    always_comb begin
        sof_accept  = in_valid && in_sof;
        len_clamped = ((cfg_line_len == '0) || (cfg_line_len > MAX_LEN)) ? MAX_LEN : cfg_line_len;
        eff_len     = (sof_accept || !len_loaded_reg) ? len_clamped : len_reg;
        eff_col     = sof_accept ? '0 : col_reg;
        eff_sel     = sof_accept ? '0 : wr_sel_reg;
        eff_filled  = sof_accept ? '0 : filled_reg;
        at_eol      = ({1'b0, eff_col} == (eff_len - 1'b1));
        sel_adv     = (eff_sel == LAST_SEL) ? '0 : eff_sel + 1'b1;
        filled_adv  = (eff_filled == LAST_SEL) ? eff_filled : eff_filled + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            wr_sel_reg     <= '0;
            filled_reg     <= '0;
            len_reg        <= '0;
            len_loaded_reg <= 1'b0;
            tap_sel_reg    <= '0;
            pix_reg        <= '0;
            have_data_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_eol_reg    <= 1'b0;
            out_col_reg    <= '0;
        end else begin
            len_loaded_reg <= 1'b1;
            if (!len_loaded_reg || sof_accept) begin
                len_reg <= len_clamped;
            end
            out_valid_reg <= 1'b0;
            out_eol_reg   <= 1'b0;
            if (in_valid) begin
                col_reg       <= at_eol ? '0 : eff_col + 1'b1;
                wr_sel_reg    <= at_eol ? sel_adv : eff_sel;
                filled_reg    <= at_eol ? filled_adv : eff_filled;
                tap_sel_reg   <= eff_sel;
                pix_reg       <= data_in;
                have_data_reg <= 1'b1;
                // Older lines are only trustworthy once the ring is full.
                out_valid_reg <= (eff_filled == LAST_SEL);
                out_eol_reg   <= (eff_filled == LAST_SEL) && at_eol;
                out_col_reg   <= eff_col;
            end
        end
    end

    // RAM banks: the bank holding the current line is written, every other
    // bank is read at the same column with a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [0:MAX_LENGTH-1];
            logic [DATA_WIDTH-1:0] rd_data_reg;

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    if (eff_sel == SEL_W'(gi)) begin
                        mem[eff_col] <= data_in;
                    end else begin
                        rd_data_reg <= mem[eff_col];
                    end
                end
            end

            assign rd_bus[gi] = rd_data_reg;
        end
    endgenerate

    // Tap k comes from the bank written k lines before the current one.
    always_comb begin
        int idx;
        idx      = 0;
        data_out = '0;
        if (have_data_reg) begin
            data_out[DATA_WIDTH-1:0] = pix_reg;
            for (int k = 1; k < NUM_LINES; k++) begin
                idx = int'(tap_sel_reg) - k;
                if (idx < 0) begin
                    idx = idx + NUM_LINES;
                end
                data_out[k*DATA_WIDTH +: DATA_WIDTH] = rd_bus[SEL_W'(idx)];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_eol   = out_eol_reg;
    assign out_col   = out_col_reg;

endmodule

// File: tb/tb_multi_linebuffer.sv
module tb_multi_linebuffer;

    localparam int DW   = 16;
    localparam int AW   = 11;
    localparam int MAXL = 1920;
    localparam int NL   = 3;
    localparam int KEY  = 4096; // model key stride per line

    logic          clk;
    logic          rst_n;
    logic [AW:0]   cfg_line_len;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_sof;
    logic [NL*DW-1:0] data_out;
    logic          out_valid;
    logic          out_eol;
    logic [AW-1:0] out_col;

    logic [AW:0]   cfg2;
    logic [DW-1:0] data_in2;
    logic          in_valid2;
    logic          in_sof2;
    logic [2*DW-1:0] data_out2;
    logic          out_valid2;
    logic          out_eol2;
    logic [AW-1:0] out_col2;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as a plain (line, column) -> pixel map.
    logic [DW-1:0] hist [int];
    int            m_line, m_col, m_len;
    logic          exp_valid, exp_eol, exp_known;
    logic [AW-1:0] exp_col;
    logic [NL*DW-1:0] exp_data;

    multi_linebuffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LENGTH(MAXL), .NUM_LINES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_line_len(cfg_line_len), .data_in(data_in),
        .in_valid(in_valid), .in_sof(in_sof), .data_out(data_out),
        .out_valid(out_valid), .out_eol(out_eol), .out_col(out_col)
    );

    multi_linebuffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LENGTH(MAXL), .NUM_LINES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_line_len(cfg2), .data_in(data_in2),
        .in_valid(in_valid2), .in_sof(in_sof2), .data_out(data_out2),
        .out_valid(out_valid2), .out_eol(out_eol2), .out_col(out_col2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_len(input int c);
        return (c == 0 || c > MAXL) ? MAXL : c;
    endfunction

    task automatic model_reset();
        m_line = 0;
        m_col = 0;
        m_len = clamp_len(int'(cfg_line_len));
        exp_valid = 1'b0;
        exp_known = 1'b0;
        hist.delete();
    endtask

    // Drive one cycle into the main DUT and update the model's expectation.
    task automatic drive(input logic v, input logic s, input logic [DW-1:0] p);
        in_valid = v;
        in_sof   = s;
        data_in  = p;
        if (v) begin
            if (s) begin
                m_line = 0;
                m_col  = 0;
                m_len  = clamp_len(int'(cfg_line_len));
                hist.delete();
            end
            hist[m_line*KEY + m_col] = p;
            exp_valid = (m_line >= NL - 1);
            exp_col   = AW'(m_col);
            exp_eol   = (m_col == m_len - 1);
            if (exp_valid) begin
                for (int k = 0; k < NL; k++) begin
                    exp_data[k*DW +: DW] = hist[(m_line - k)*KEY + m_col];
                end
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
            m_col++;
            if (m_col == m_len) begin
                m_col = 0;
                m_line++;
            end
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_eol, out_col, data_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b c=%0d d=%h exp all 0", out_valid, out_eol, out_col, data_out);
        end
        checks++;
        if ({out_valid2, out_eol2, out_col2, data_out2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs2 got v=%b e=%b c=%0d d=%h exp all 0", out_valid2, out_eol2, out_col2, data_out2);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scenario1(input string tag);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i == 0, DW'(i));
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s_valid px=%0d got %b exp %b", tag, i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({data_out, out_col, out_eol} !== {exp_data, exp_col, exp_eol}) begin
                    errors++;
                    $display("FAIL %s_taps px=%0d got d=%h c=%0d e=%b exp d=%h c=%0d e=%b",
                             tag, i, data_out, out_col, out_eol, exp_data, exp_col, exp_eol);
                end
            end
            if (i == 8) begin
                checks++;
                if ({data_out, out_col} !== {16'd0, 16'd4, 16'd8, 11'd0}) begin
                    errors++;
                    $display("FAIL %s_px8 got d=%h c=%0d exp d=000000040008 c=0", tag, data_out, out_col);
                end
            end
            if (i == 11) begin
                checks++;
                if ({data_out, out_eol} !== {16'd3, 16'd7, 16'd11, 1'b1}) begin
                    errors++;
                    $display("FAIL %s_px11 got d=%h e=%b exp d=00030007000b e=1", tag, data_out, out_eol);
                end
            end
        end
    endtask

    task automatic test_basic();
        cfg_line_len = 12'd4;
        run_scenario1("basic");
        // Continue the frame with random pixels
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, DW'($urandom));
            checks++;
            if ({out_valid, data_out, out_col, out_eol} !== {exp_valid, exp_data, exp_col, exp_eol}) begin
                errors++;
                $display("FAIL basic_rand i=%0d got v=%b d=%h c=%0d e=%b exp v=%b d=%h c=%0d e=%b",
                         i, out_valid, data_out, out_col, out_eol, exp_valid, exp_data, exp_col, exp_eol);
            end
        end
    endtask

    task automatic test_gaps();
        cfg_line_len = 12'd4;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, i == 0, DW'($urandom));
            checks++;
            if (out_valid !== exp_valid) begin
                errors++;
                $display("FAIL gaps_valid px=%0d got %b exp %b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({data_out, out_col, out_eol} !== {exp_data, exp_col, exp_eol}) begin
                    errors++;
                    $display("FAIL gaps_taps px=%0d got d=%h c=%0d e=%b exp d=%h c=%0d e=%b",
                             i, data_out, out_col, out_eol, exp_data, exp_col, exp_eol);
                end
            end
            drive(1'b0, 1'b0, DW'($urandom));
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gaps_idle_valid px=%0d got %b exp 0", i, out_valid);
            end
            if (exp_known) begin
                checks++;
                if (data_out !== exp_data) begin
                    errors++;
                    $display("FAIL gaps_hold px=%0d got %h exp %h", i, data_out, exp_data);
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        cfg_line_len = 12'd4;
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, DW'($urandom));
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i == 0, DW'(100 + i));
            checks++;
            if (out_valid !== (i >= 8)) begin
                errors++;
                $display("FAIL sof_valid px=%0d got %b exp %b", i, out_valid, (i >= 8));
            end
            if (exp_valid) begin
                checks++;
                if ({data_out, out_col, out_eol} !== {exp_data, exp_col, exp_eol}) begin
                    errors++;
                    $display("FAIL sof_taps px=%0d got d=%h c=%0d e=%b exp d=%h c=%0d e=%b",
                             i, data_out, out_col, out_eol, exp_data, exp_col, exp_eol);
                end
            end
            if (i == 8) begin
                checks++;
                if (data_out !== {16'd100, 16'd104, 16'd108}) begin
                    errors++;
                    $display("FAIL sof_first got %h exp 00640068006c", data_out);
                end
            end
        end
    endtask

    task automatic test_clamp(input int cfg);
        int first_eol_col;
        first_eol_col = -1;
        cfg_line_len = (AW+1)'(cfg);
        drive(1'b1, 1'b1, DW'($urandom));
        // Length changes outside sof must be ignored
        cfg_line_len = (AW+1)'($urandom_range(1, 8));
        for (int i = 1; i < 3*MAXL + 2; i++) begin
            drive(1'b1, 1'b0, DW'($urandom));
            checks++;
            if ({out_valid, out_eol} !== {exp_valid, exp_eol && exp_valid}) begin
                errors++;
                $display("FAIL clamp_flags cfg=%0d px=%0d got v=%b e=%b exp v=%b e=%b",
                         cfg, i, out_valid, out_eol, exp_valid, exp_eol && exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if ({data_out, out_col} !== {exp_data, exp_col}) begin
                    errors++;
                    $display("FAIL clamp_taps cfg=%0d px=%0d got d=%h c=%0d exp d=%h c=%0d",
                             cfg, i, data_out, out_col, exp_data, exp_col);
                end
                if (out_eol && first_eol_col < 0) first_eol_col = int'(out_col);
            end
        end
        checks++;
        if (first_eol_col != MAXL - 1) begin
            errors++;
            $display("FAIL clamp_first_eol cfg=%0d got col %0d exp %0d", cfg, first_eol_col, MAXL - 1);
        end
        checks++;
        if (out_col !== AW'(1)) begin
            errors++;
            $display("FAIL clamp_wrap cfg=%0d got col %0d exp 1", cfg, out_col);
        end
    endtask

    task automatic test_async_reset();
        cfg_line_len = 12'd4;
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, DW'(i));
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got v=%b exp 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_eol, data_out} !== '0) begin
            errors++;
            $display("FAIL areset_async got v=%b e=%b d=%h exp all 0", out_valid, out_eol, data_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        run_scenario1("areset");
    endtask

    task automatic test_two_lines();
        logic [DW-1:0] px [3];
        logic [2*DW-1:0] exp2;
        px[0] = 16'd5;
        px[1] = 16'd6;
        px[2] = 16'd7;
        cfg2 = 12'd1;
        for (int i = 0; i < 3; i++) begin
            in_valid2 = 1'b1;
            in_sof2   = (i == 0);
            data_in2  = px[i];
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            in_sof2   = 1'b0;
            checks++;
            if (out_valid2 !== (i > 0)) begin
                errors++;
                $display("FAIL two_valid px=%0d got %b exp %b", i, out_valid2, (i > 0));
            end
            if (i > 0) begin
                exp2 = {px[i-1], px[i]};
                checks++;
                if ({data_out2, out_col2, out_eol2} !== {exp2, 11'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL two_taps px=%0d got d=%h c=%0d e=%b exp d=%h c=0 e=1",
                             i, data_out2, out_col2, out_eol2, exp2);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid2, data_out2} !== {1'b0, 16'd6, 16'd7}) begin
            errors++;
            $display("FAIL two_idle got v=%b d=%h exp v=0 d=00060007", out_valid2, data_out2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_line_len = 12'd4;
        data_in = '0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        cfg2 = 12'd1;
        data_in2 = '0;
        in_valid2 = 1'b0;
        in_sof2 = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_mid_sof();
        test_clamp(0);
        test_clamp(MAXL + 5);
        test_async_reset();
        test_two_lines();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
